// File: rtl/ram_init_param.sv
// Single-port synchronous data RAM with a zero-fill / stream-load init engine.
// CPU port: write on WE, otherwise a registered read; blocked while busy.
module ram_init_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  readValid,
    input  logic                  initStart,
    input  logic                  initMode,
    input  logic [ADDR_WIDTH:0]   initCount,
    input  logic [DATA_WIDTH-1:0] loadData,
    input  logic                  loadValid,
    output logic                  loadReady,
    output logic                  busy,
    output logic                  initDone
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]     rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    rvalid_q, rvalid_d;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        dout_d    = dout_q;
        rvalid_d  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = dataIn;
        unique case (state_q)
            IDLE: begin
                if (WE) begin
                    mem_we = 1'b1;
                end else begin
                    dout_d   = mem[address];
                    rvalid_d = 1'b1;
                end
                // The CPU access above still completes in the start cycle.
                if (initStart) begin
                    ptr_d = '0;
                    if (!initMode) begin
                        state_d = CLEAR;
                    end else if (initCount == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                        rem_d   = (initCount > DEPTH_W) ? DEPTH_W : initCount;
                    end
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + PTR_ONE;
                if (ptr_q == LAST) begin
                    state_d = DONE;
                end
            end
            LOAD: begin
                if (loadValid) begin
                    mem_we    = 1'b1;
                    mem_addr  = ptr_q;
                    mem_wdata = loadData;
                    ptr_d     = ptr_q + PTR_ONE;
                    rem_d     = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            dout_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            dout_q   <= dout_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign dataOut   = dout_q;
    assign readValid = rvalid_q;
    assign loadReady = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign initDone  = (state_q == DONE);

endmodule

// File: tb/tb_ram_init_param.sv
// Bench for ram_init_param: scoreboarded CPU reads against a word-array model,
// plus init-engine timing checks on a default and a 16x8 instance.
module tb_ram_init_param;

    logic       clock;
    logic       resetN;
    logic [4:0] address;
    logic       WE;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic       readValid;
    logic       initStart;
    logic       initMode;
    logic [5:0] initCount;
    logic [7:0] loadData;
    logic       loadValid;
    logic       loadReady;
    logic       busy;
    logic       initDone;

    logic [2:0]  s_address;
    logic        s_WE;
    logic [15:0] s_dataIn;
    logic [15:0] s_dataOut;
    logic        s_readValid;
    logic        s_initStart;
    logic        s_initMode;
    logic [3:0]  s_initCount;
    logic [15:0] s_loadData;
    logic        s_loadValid;
    logic        s_loadReady;
    logic        s_busy;
    logic        s_initDone;

    ram_init_param dut (
        .clock(clock), .resetN(resetN), .address(address), .WE(WE),
        .dataIn(dataIn), .dataOut(dataOut), .readValid(readValid),
        .initStart(initStart), .initMode(initMode), .initCount(initCount),
        .loadData(loadData), .loadValid(loadValid), .loadReady(loadReady),
        .busy(busy), .initDone(initDone)
    );

    ram_init_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut_s (
        .clock(clock), .resetN(resetN), .address(s_address), .WE(s_WE),
        .dataIn(s_dataIn), .dataOut(s_dataOut), .readValid(s_readValid),
        .initStart(s_initStart), .initMode(s_initMode),
        .initCount(s_initCount), .loadData(s_loadData),
        .loadValid(s_loadValid), .loadReady(s_loadReady),
        .busy(s_busy), .initDone(s_initDone)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  model [32];
    logic [7:0]  wbuf  [64];
    logic [7:0]  exp_q [$];
    logic [15:0] s_model [8];
    logic [15:0] s_w [16];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented read word must match the queue head.
    always @(negedge clock) begin
        if (resetN && readValid) begin
            if (exp_q.size() == 0) check("unexpected readValid", 1, 0);
            else check("read data", {24'd0, dataOut}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Idle CPU cycle: rewrite address 31 with its current value.
    task automatic set_nop();
        WE      = 1'b1;
        address = 5'd31;
        dataIn  = model[31];
    endtask

    task automatic cpu_write(int a, logic [7:0] d);
        WE      = 1'b1;
        address = 5'(a);
        dataIn  = d;
        tick();
        model[a] = d;
        set_nop();
    endtask

    task automatic cpu_read(int a);
        WE      = 1'b0;
        address = 5'(a);
        exp_q.push_back(model[a]);
        tick();
        set_nop();
    endtask

    task automatic start_init(logic mode, int count);
        initStart = 1'b1;
        initMode  = mode;
        initCount = 6'(count);
        tick();
        initStart = 1'b0;
    endtask

    task automatic measure_busy(output int cyc, output int done_at);
        cyc     = 0;
        done_at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy) break;
            cyc++;
            if (initDone) done_at = cyc;
        end
    endtask

    // mode 0: valid always; 1: two-cycle gap before word 2; 2: random valid.
    task automatic run_stream(int mode, output int acc, output int busy_cyc,
                              output int hs_last, output int done_at);
        int stall;
        stall    = 0;
        acc      = 0;
        busy_cyc = 0;
        hs_last  = -1;
        done_at  = -1;
        for (int it = 0; it < 400; it++) begin
            logic lv;
            if (mode == 0) lv = 1'b1;
            else if (mode == 1) begin
                if (acc == 2 && stall < 2) begin
                    lv = 1'b0;
                    stall++;
                end else lv = 1'b1;
            end else lv = ($urandom_range(0, 1) == 1);
            loadValid = lv;
            loadData  = wbuf[acc];
            @(negedge clock);
            if (!busy) break;
            busy_cyc++;
            if (initDone) done_at = it;
            if (loadValid && loadReady) begin
                hs_last = it;
                acc++;
            end
            @(posedge clock);
            #1;
        end
        loadValid = 1'b0;
        check("stream terminates", {31'd0, busy}, 0);
    endtask

    task automatic s_write(int a, logic [15:0] d);
        s_WE      = 1'b1;
        s_address = 3'(a);
        s_dataIn  = d;
        tick();
        s_model[a] = d;
        s_WE       = 1'b0;
        s_address  = 3'd0;
    endtask

    task automatic s_read_chk(int a);
        s_WE      = 1'b0;
        s_address = 3'(a);
        tick();
        check("small read data", {16'd0, s_dataOut}, {16'd0, s_model[a]});
        check("small readValid", {31'd0, s_readValid}, 1);
        s_address = 3'd0;
    endtask

    initial begin
        int cyc, done_at, acc, hs_last, n;

        resetN    = 1'b0;
        model[31] = 8'h00;
        set_nop();
        initStart = 1'b0;
        initMode  = 1'b0;
        initCount = '0;
        loadData  = '0;
        loadValid = 1'b0;
        s_WE = 1'b0; s_address = '0; s_dataIn = '0; s_initStart = 1'b0;
        s_initMode = 1'b0; s_initCount = '0; s_loadData = '0;
        s_loadValid = 1'b0;
        repeat (3) tick();
        check("reset dataOut", {24'd0, dataOut}, 0);
        check("reset readValid", {31'd0, readValid}, 0);
        check("reset busy", {31'd0, busy}, 0);
        check("reset loadReady", {31'd0, loadReady}, 0);
        check("reset initDone", {31'd0, initDone}, 0);
        resetN = 1'b1;
        tick();

        for (int a = 0; a < 32; a++) cpu_write(a, 8'($urandom));
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1)
                cpu_write($urandom_range(0, 31), 8'($urandom));
            else
                cpu_read($urandom_range(0, 31));
        end

        cpu_write(3, 8'hA5);
        cpu_read(3);
        cpu_write(4, 8'h11);
        check("dataOut held on write", {24'd0, dataOut}, 32'hA5);
        check("readValid low on write", {31'd0, readValid}, 0);

        for (int a = 0; a < 32; a++) cpu_write(a, 8'hFF);
        start_init(1'b0, 0);
        for (int a = 0; a < 32; a++) model[a] = 8'h00;
        set_nop();
        measure_busy(cyc, done_at);
        check("zero-fill busy cycles", cyc, 33);
        check("zero-fill initDone cycle", done_at, 33);
        for (int a = 0; a < 32; a++) cpu_read(a);

        wbuf[0] = 8'h80; wbuf[1] = 8'h3E; wbuf[2] = 8'h80; wbuf[3] = 8'h3F;
        for (int i = 4; i < 64; i++) wbuf[i] = 8'($urandom);
        start_init(1'b1, 4);
        run_stream(1, acc, cyc, hs_last, done_at);
        check("stall load accepted", acc, 4);
        check("stall load initDone after last hs", done_at, hs_last + 1);
        for (int a = 0; a < 4; a++) model[a] = wbuf[a];
        set_nop();
        for (int a = 0; a < 5; a++) cpu_read(a);

        n = $urandom_range(5, 20);
        for (int i = 0; i < 64; i++) wbuf[i] = 8'($urandom);
        start_init(1'b1, n);
        run_stream(0, acc, cyc, hs_last, done_at);
        check("full-rate load accepted", acc, n);
        check("full-rate load busy cycles", cyc, n + 1);
        check("full-rate initDone after last hs", done_at, hs_last + 1);
        for (int a = 0; a < n; a++) model[a] = wbuf[a];
        set_nop();
        for (int a = 0; a < 32; a++) cpu_read(a);

        n = $urandom_range(33, 63);
        for (int i = 0; i < 64; i++) wbuf[i] = 8'($urandom);
        start_init(1'b1, n);
        run_stream(2, acc, cyc, hs_last, done_at);
        check("oversize load clamped", acc, 32);
        check("oversize initDone after last hs", done_at, hs_last + 1);
        for (int a = 0; a < 32; a++) model[a] = wbuf[a];
        set_nop();
        for (int a = 0; a < 32; a++) cpu_read(a);

        cpu_write(20, 8'h5A);
        cpu_read(20);
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        start_init(1'b1, 8);
        loadValid = 1'b1;
        loadData  = wbuf[0];
        tick();
        loadData  = wbuf[1];
        WE        = 1'b1;
        address   = 5'd10;
        dataIn    = 8'hFF;
        initStart = 1'b1;
        initMode  = 1'b0;
        tick();
        loadValid = 1'b0;
        initStart = 1'b0;
        set_nop();
        check("still loading busy", {31'd0, busy}, 1);
        check("still loading ready", {31'd0, loadReady}, 1);
        #2 resetN = 1'b0;
        #1;
        check("abort dataOut", {24'd0, dataOut}, 0);
        check("abort readValid", {31'd0, readValid}, 0);
        check("abort busy", {31'd0, busy}, 0);
        check("abort loadReady", {31'd0, loadReady}, 0);
        check("abort initDone", {31'd0, initDone}, 0);
        tick();
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("no initDone after abort", {31'd0, initDone}, 0);
            check("idle after abort", {31'd0, busy}, 0);
        end
        model[0] = wbuf[0];
        model[1] = wbuf[1];
        cpu_read(0);
        cpu_read(1);
        cpu_read(2);
        cpu_read(10);

        for (int a = 0; a < 8; a++) s_write(a, 16'h1000 + 16'(a));
        s_initStart = 1'b1;
        s_initMode  = 1'b1;
        s_initCount = 4'd0;
        tick();
        s_initStart = 1'b0;
        check("small count0 initDone", {31'd0, s_initDone}, 1);
        check("small count0 busy", {31'd0, s_busy}, 1);
        tick();
        check("small count0 done over", {31'd0, s_busy}, 0);
        s_read_chk(0);
        s_read_chk(5);

        for (int i = 0; i < 16; i++) s_w[i] = 16'($urandom);
        s_initStart = 1'b1;
        s_initMode  = 1'b1;
        s_initCount = 4'd12;
        tick();
        s_initStart = 1'b0;
        acc = 0;
        cyc = 0;
        for (int it = 0; it < 50; it++) begin
            s_loadValid = 1'b1;
            s_loadData  = s_w[acc];
            @(negedge clock);
            if (!s_busy) break;
            cyc++;
            if (s_loadValid && s_loadReady) acc++;
            @(posedge clock);
            #1;
        end
        s_loadValid = 1'b0;
        check("small clamp accepted", acc, 8);
        check("small clamp busy cycles", cyc, 9);
        for (int a = 0; a < 8; a++) s_model[a] = s_w[a];
        tick();
        for (int a = 0; a < 8; a++) s_read_chk(a);
        s_write(7, 16'hBEEF);
        s_read_chk(7);

        repeat (3) tick();
        check("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_init_param.md
# ram_init_param

Parametrised single-port synchronous data RAM for the microprocessor datapath. It has a built-in initialisation engine that can either zero-fill the whole array or stream-load a program/data image through a valid/ready port. Initialisation runs without a test-only preload path. The CPU-side port keeps the 8-bit generation's semantics: write when WE, otherwise registered read.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH (derived, not overridable)

Ports:
- clock  in  1  single clock, all state on rising edge
- resetN  in  1  asynchronous, active-low reset
- address  in  ADDR_WIDTH  CPU word address
- WE  in  1  CPU write enable; 0 = read request
- dataIn  in  DATA_WIDTH  CPU write data
- dataOut  out  DATA_WIDTH  registered read data
- readValid  out  1  high for the cycle in which dataOut holds a freshly read word
- initStart  in  1  start initialisation; sampled only in IDLE
- initMode  in  1  0 = zero-fill, 1 = stream load; sampled with initStart
- initCount  in  ADDR_WIDTH+1  words to stream-load; sampled with initStart
- loadData  in  DATA_WIDTH  stream word
- loadValid  in  1  stream word present
- loadReady  out  1  engine accepts a stream word
- busy  out  1  initialisation in progress; CPU port blocked
- initDone  out  1  one-cycle pulse at end of initialisation

## Operation
- FSM states: IDLE, CLEAR, LOAD, DONE. Reset state is IDLE.
- Reset values: dataOut = 0, readValid = 0, loadReady = 0, busy = 0, initDone = 0, pointer = 0. Array contents are not reset.
- IDLE, CPU access:
  - WE=1: RAM[address] <= dataIn. dataOut holds its value. readValid = 0 next cycle.
  - WE=0: dataOut <= RAM[address]. readValid = 1 next cycle.
- IDLE, initStart=1: the CPU access presented in the same cycle is still performed. The FSM then moves as follows:
  - initMode=0: go to CLEAR with pointer = 0.
  - initMode=1 and initCount=0: go directly to DONE. No writes occur.
  - initMode=1 and initCount nonzero: go to LOAD with pointer = 0 and remaining = min(initCount, DEPTH).
- CLEAR:
  - Each cycle write 0 to RAM[pointer], then pointer++.
  - After the write to DEPTH-1, go to DONE. The pointer must not wrap into a second pass.
- LOAD:
  - loadReady = 1 (combinational from state).
  - On loadValid & loadReady: RAM[pointer] <= loadData, pointer++, remaining--.
  - After the last accepted word, go to DONE. Words at or above remaining's original count are untouched.
  - loadValid low stalls indefinitely with no timeout.
- DONE: initDone = 1 and busy = 1 for one cycle, then IDLE.
- busy = 1 in CLEAR, LOAD and DONE. While busy:
  - WE and reads are ignored.
  - dataOut holds and readValid = 0.
  - initStart is ignored.
- Reset asserted mid-initialisation:
  - Immediately return to IDLE. All outputs take their reset values.
  - Words already written stay written. No initDone pulse.

## Timing
- Read latency is 1 cycle. Address sampled at edge N appears on dataOut after edge N, with readValid high for that cycle only.
- Write takes effect at the sampling edge. A read of the same address in the next cycle returns the new word.
- busy rises after the edge that samples initStart.
- Zero-fill: busy is high for exactly DEPTH+1 cycles (DEPTH write cycles plus DONE). That is 33 cycles at default parameters.
- Stream load: peak throughput is one word per cycle. With loadValid held high, busy lasts count+1 cycles.
- initDone rises the cycle after the final write. The CPU port is usable the cycle after initDone.

## Test plan
- Reset: hold resetN=0 mid-run -> dataOut=0x00, readValid=0, busy=0, loadReady=0, initDone=0 asynchronously.
- CPU access: write 0xA5 to address 3, then read address 3 -> dataOut=0xA5 one cycle later with a one-cycle readValid. A following WE=1 cycle leaves dataOut at 0xA5 and readValid=0.
- Zero-fill: prefill all 32 words with 0xFF, pulse initStart with initMode=0 -> busy high for 33 cycles with initDone in the last. Reads of addresses 0..31 then all return 0x00.
- Stream load: initCount=4, data 0x80, 0x3E, 0x80, 0x3F, with loadValid dropped for 2 cycles between words 2 and 3 -> addresses 0..3 hold those values and address 4 is unchanged. initDone comes one cycle after the 4th handshake.
- Blocking and abort: during LOAD, WE=1 to address 10 with 0xFF and a second initStart are both ignored (address 10 unchanged). resetN pulsed after 2 accepted words -> IDLE, busy=0, addresses 0..1 loaded, no initDone.
- Parameters and edge cases, with DATA_WIDTH=16 and ADDR_WIDTH=3:
  - initCount=0 -> initDone the cycle after initStart, no writes.
  - initCount=12 -> exactly 8 words accepted, then initDone.
  - 0xBEEF written at address 7 reads back intact.
